// File: rtl/instr_fill_buf.sv
// Instruction store fed by a fill FIFO. Fetch reads every cycle with priority, except in the
// cycle after a read miss, when a queued fill beat is written instead.
module instr_fill_buf #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        FillVal_FL0,
   input  logic [31:0] FillAddr_FL0,
   input  logic [31:0] FillData_FL0,
   output logic        FillRdy_FL0,
   input  logic        FillInv_FL0,
   input  logic        PcReqVal_SY0,
   input  logic [31:0] PcReq_SY0,
   output logic [31:0] InstrFill_SY0,
   output logic        InstrHit_SY0,
   output logic        FillBusy_SY0,
   output logic        DropErr_SY0
);

   localparam int unsigned Words = 2 ** ADDR_W;
   localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW  = PtrW + 1;

   typedef enum logic [1:0] {ArbInv, ArbRead, ArbPop, ArbIdle} arbSel_t;

   // Fill FIFO, entries hold the word address (byte address bits [31:2]).
   logic [29:0]     fifoAddr [FIFO_DEPTH];
   logic [31:0]     fifoData [FIFO_DEPTH];
   logic [PtrW-1:0] wrPtrQ, rdPtrQ;
   logic [CntW-1:0] cntQ, cntD;

   logic [31:0]      mem [Words];
   logic [Words-1:0] validQ;

   logic [31:0] instrFillQ, instrFillD;
   logic        instrHitQ, instrHitD;
   logic        dropErrQ, dropErrD;
   logic        missQ, missD;

   arbSel_t     arbSel;
   logic        fillRdy, fifoEmpty, push, pop, memWe;
   logic [29:0] headAddr;
   logic [31:0] headData;
   logic [ADDR_W-1:0] headIdx, pcIdx;
   logic        headInRange, pcInRange;
   logic        unusedAddrBits;

   assign unusedAddrBits = ^{FillAddr_FL0[1:0], PcReq_SY0[1:0]};

   assign fillRdy   = (cntQ != CntW'(FIFO_DEPTH));
   assign fifoEmpty = (cntQ == '0);
   assign push      = FillVal_FL0 & fillRdy & ~FillInv_FL0;

   assign headAddr    = fifoAddr[rdPtrQ];
   assign headData    = fifoData[rdPtrQ];
   assign headIdx     = headAddr[ADDR_W-1:0];
   assign headInRange = (headAddr[29:ADDR_W] == '0);
   assign pcIdx       = PcReq_SY0[ADDR_W+1:2];
   assign pcInRange   = (PcReq_SY0[31:ADDR_W+2] == '0);

   // One store access per cycle, decided on pre-edge FIFO state.
   always_comb begin
      if (FillInv_FL0) begin
         arbSel = ArbInv;
      end else if (PcReqVal_SY0 && !missQ) begin
         arbSel = ArbRead;
      end else if (!fifoEmpty) begin
         arbSel = ArbPop;
      end else begin
         arbSel = ArbIdle;
      end
   end

   assign pop   = (arbSel == ArbPop);
   assign memWe = pop & headInRange;

   always_comb begin
      instrFillD = '0;
      instrHitD  = 1'b0;
      dropErrD   = dropErrQ;
      missD      = 1'b0;
      unique case (arbSel)
         ArbInv: begin
            dropErrD = 1'b0;
         end
         ArbRead: begin
            if (pcInRange) begin
               instrFillD = mem[pcIdx];
               instrHitD  = validQ[pcIdx];
            end
            missD = ~instrHitD;
         end
         ArbPop: begin
            if (!headInRange) begin
               dropErrD = 1'b1;
            end else if (PcReqVal_SY0 && (headIdx == pcIdx)) begin
               // Write-first bypass of the word being filled.
               instrFillD = headData;
               instrHitD  = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      cntD = cntQ;
      if (push && !pop) begin
         cntD = cntQ + CntW'(1);
      end else if (!push && pop) begin
         cntD = cntQ - CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtrQ     <= '0;
         rdPtrQ     <= '0;
         cntQ       <= '0;
         validQ     <= '0;
         instrFillQ <= '0;
         instrHitQ  <= 1'b0;
         dropErrQ   <= 1'b0;
         missQ      <= 1'b0;
      end else begin
         instrFillQ <= instrFillD;
         instrHitQ  <= instrHitD;
         dropErrQ   <= dropErrD;
         missQ      <= missD;
         if (FillInv_FL0) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            cntQ   <= '0;
            validQ <= '0;
         end else begin
            cntQ <= cntD;
            if (push) begin
               wrPtrQ <= wrPtrQ + PtrW'(1);
            end
            if (pop) begin
               rdPtrQ <= rdPtrQ + PtrW'(1);
            end
            if (memWe) begin
               validQ[headIdx] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifoAddr[wrPtrQ] <= FillAddr_FL0[31:2];
         fifoData[wrPtrQ] <= FillData_FL0;
      end
   end

   always_ff @(posedge clk) begin
      if (memWe) begin
         mem[headIdx] <= headData;
      end
   end

   assign FillRdy_FL0   = fillRdy;
   assign FillBusy_SY0  = ~fifoEmpty;
   assign InstrFill_SY0 = instrFillQ;
   assign InstrHit_SY0  = instrHitQ;
   assign DropErr_SY0   = dropErrQ;

endmodule

// File: tb/tb_instr_fill_buf.sv
// Directed scenarios followed by random traffic, all checked against a queue/array model.
module tb_instr_fill_buf;

   logic        clk = 1'b0;
   logic        reset;
   logic        FillVal_FL0;
   logic [31:0] FillAddr_FL0;
   logic [31:0] FillData_FL0;
   logic        FillRdy_FL0;
   logic        FillInv_FL0;
   logic        PcReqVal_SY0;
   logic [31:0] PcReq_SY0;
   logic [31:0] InstrFill_SY0;
   logic        InstrHit_SY0;
   logic        FillBusy_SY0;
   logic        DropErr_SY0;

   int total = 0;
   int bad   = 0;

   // Reference model: byte-address queue plus a word store with valid flags.
   logic [31:0] qAddr [$];
   logic [31:0] qData [$];
   logic [31:0] mMem   [256];
   bit          mValid [256];
   bit          mKnown [256];
   logic [31:0] mFill;
   bit          mHit, mDrop, mMiss;

   always #5 clk = ~clk;

   instr_fill_buf dut (
      .clk          (clk),
      .reset        (reset),
      .FillVal_FL0  (FillVal_FL0),
      .FillAddr_FL0 (FillAddr_FL0),
      .FillData_FL0 (FillData_FL0),
      .FillRdy_FL0  (FillRdy_FL0),
      .FillInv_FL0  (FillInv_FL0),
      .PcReqVal_SY0 (PcReqVal_SY0),
      .PcReq_SY0    (PcReq_SY0),
      .InstrFill_SY0(InstrFill_SY0),
      .InstrHit_SY0 (InstrHit_SY0),
      .FillBusy_SY0 (FillBusy_SY0),
      .DropErr_SY0  (DropErr_SY0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      qAddr.delete();
      qData.delete();
      for (int i = 0; i < 256; i++) mValid[i] = 1'b0;
      mFill = '0;
      mHit  = 1'b0;
      mDrop = 1'b0;
      mMiss = 1'b0;
   endtask

   task automatic chkResetState(input string tag);
      chk({tag, ".hit"}, {31'd0, InstrHit_SY0}, 32'd0);
      chk({tag, ".fill"}, InstrFill_SY0, 32'd0);
      chk({tag, ".drop"}, {31'd0, DropErr_SY0}, 32'd0);
      chk({tag, ".rdy"}, {31'd0, FillRdy_FL0}, 32'd1);
      chk({tag, ".busy"}, {31'd0, FillBusy_SY0}, 32'd0);
   endtask

   // One clock: model the edge from the current inputs, then compare after it.
   task automatic tick();
      int unsigned sz;
      bit          rdy, nh, nm, fk;
      logic [31:0] nf, ha, hd;
      sz = qAddr.size();
      rdy = (sz < 4);
      nf = '0;
      nh = 1'b0;
      nm = 1'b0;
      fk = 1'b1;
      chk("fillRdy", {31'd0, FillRdy_FL0}, {31'd0, rdy});
      chk("fillBusy", {31'd0, FillBusy_SY0}, {31'd0, sz != 0});
      if (FillInv_FL0) begin
         for (int i = 0; i < 256; i++) mValid[i] = 1'b0;
         qAddr.delete();
         qData.delete();
         mDrop = 1'b0;
      end else if (PcReqVal_SY0 && !mMiss) begin
         if (PcReq_SY0 < 32'h400) begin
            nh = mValid[PcReq_SY0[9:2]];
            nf = mMem[PcReq_SY0[9:2]];
            fk = mKnown[PcReq_SY0[9:2]];
         end
         nm = !nh;
      end else if (sz != 0) begin
         ha = qAddr.pop_front();
         hd = qData.pop_front();
         if (ha < 32'h400) begin
            mMem[ha[9:2]]   = hd;
            mValid[ha[9:2]] = 1'b1;
            mKnown[ha[9:2]] = 1'b1;
            if (PcReqVal_SY0 && ha[9:2] == PcReq_SY0[9:2]) begin
               nh = 1'b1;
               nf = hd;
            end
         end else begin
            mDrop = 1'b1;
         end
      end
      if (!FillInv_FL0 && FillVal_FL0 && rdy) begin
         qAddr.push_back(FillAddr_FL0);
         qData.push_back(FillData_FL0);
      end
      @(posedge clk);
      #1;
      mHit  = nh;
      mFill = nf;
      mMiss = nm;
      chk("instrHit", {31'd0, InstrHit_SY0}, {31'd0, mHit});
      if (fk) chk("instrFill", InstrFill_SY0, mFill);
      chk("dropErr", {31'd0, DropErr_SY0}, {31'd0, mDrop});
   endtask

   task automatic drive(input bit fv, input logic [31:0] fa, input logic [31:0] fd,
                        input bit inv, input bit pv, input logic [31:0] pc);
      FillVal_FL0  = fv;
      FillAddr_FL0 = fa;
      FillData_FL0 = fd;
      FillInv_FL0  = inv;
      PcReqVal_SY0 = pv;
      PcReq_SY0    = pc;
   endtask

   function automatic logic [31:0] randAddr();
      logic [31:0] a;
      a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
      if ($urandom_range(0, 19) == 0) a = a | 32'h400;
      if ($urandom_range(0, 39) == 0) a = a | 32'h8000_0000;
      return a;
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) mKnown[i] = 1'b0;
      modelReset();
      reset = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
      #12;
      chkResetState("reset");
      @(negedge clk);
      reset = 1'b1;

      // Reads of an empty store never hit.
      drive(1'b0, '0, '0, 1'b0, 1'b1, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t1.hit", {31'd0, InstrHit_SY0}, 32'd0);
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0, 32'h0);
      tick();

      // Miss, then bypassed pop, then store hits.
      drive(1'b1, 32'h4, 32'h2002_0005, 1'b0, 1'b0, 32'h4);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b1, 32'h4);
      tick();
      chk("t2.e1hit", {31'd0, InstrHit_SY0}, 32'd0);
      tick();
      chk("t2.e2hit", {31'd0, InstrHit_SY0}, 32'd1);
      chk("t2.e2fill", InstrFill_SY0, 32'h2002_0005);
      tick();
      chk("t2.e3hit", {31'd0, InstrHit_SY0}, 32'd1);
      chk("t2.e3fill", InstrFill_SY0, 32'h2002_0005);

      // Hitting reads starve pops until the FIFO is full.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h20 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b1, 32'h4);
         tick();
      end
      chk("t3.full", {31'd0, FillRdy_FL0}, 32'd0);
      drive(1'b1, 32'h30, 32'hA000_0004, 1'b0, 1'b1, 32'h4);
      tick();
      PcReqVal_SY0 = 1'b0;
      tick();
      chk("t3.rdyAgain", {31'd0, FillRdy_FL0}, 32'd1);
      PcReqVal_SY0 = 1'b1;
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 32'h4);
      for (int i = 0; i < 6; i++) tick();

      // Miss yield: reads and pops alternate, the 0x8 pop bypasses.
      drive(1'b1, 32'h10, 32'h1111_0010, 1'b0, 1'b1, 32'h4);
      tick();
      drive(1'b1, 32'h8, 32'h8888_0008, 1'b0, 1'b1, 32'h4);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b1, 32'h8);
      for (int i = 0; i < 3; i++) tick();
      chk("t4.preHit", {31'd0, InstrHit_SY0}, 32'd0);
      tick();
      chk("t4.bypHit", {31'd0, InstrHit_SY0}, 32'd1);
      chk("t4.bypFill", InstrFill_SY0, 32'h8888_0008);
      PcReq_SY0 = 32'h10;
      tick();
      chk("t4.fill10", InstrFill_SY0, 32'h1111_0010);

      // Invalidate discards the same-cycle push and all valid words.
      drive(1'b1, 32'hC, 32'hCCCC_000C, 1'b1, 1'b0, 32'h4);
      tick();
      chk("t5.busy", {31'd0, FillBusy_SY0}, 32'd0);
      drive(1'b0, '0, '0, 1'b0, 1'b1, 32'h4);
      tick();
      chk("t5.hit4", {31'd0, InstrHit_SY0}, 32'd0);
      PcReq_SY0 = 32'hC;
      tick();
      tick();
      chk("t5.hitC", {31'd0, InstrHit_SY0}, 32'd0);

      // Out-of-range fill is dropped and the error sticks until invalidate.
      drive(1'b1, 32'h400, 32'hDEAD_0400, 1'b0, 1'b0, 32'h0);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 32'h0);
      tick();
      chk("t6.drop", {31'd0, DropErr_SY0}, 32'd1);
      drive(1'b1, 32'h14, 32'h1414_0014, 1'b0, 1'b1, 32'h0);
      for (int i = 0; i < 3; i++) tick();
      chk("t6.sticky", {31'd0, DropErr_SY0}, 32'd1);
      drive(1'b0, '0, '0, 1'b1, 1'b0, 32'h0);
      tick();
      chk("t6.cleared", {31'd0, DropErr_SY0}, 32'd0);

      // Random traffic with one asynchronous reset in the middle.
      for (int n = 0; n < 800; n++) begin
         drive(1'($urandom_range(0, 2) != 0), randAddr(), $urandom,
               1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0), randAddr());
         if (n == 400) begin
            reset = 1'b0;
            #1;
            modelReset();
            chkResetState("midReset");
            @(negedge clk);
            reset = 1'b1;
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
